ifetch_line_buffer: RTL and testbench
=====================================

IFETCH_LINE_BUFFER -- requirements
Module: ifetch_line_buffer

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 8, giving the number of 64-bit words per line; legal values are 2, 4, 8 and 16.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL have port: ireq  input  ibus_req_t  fetch request (valid, addr); held stable until data_ok.
REQ-005 SHALL have port: iresp  output  ibus_resp_t  fetch response (addr_ok, data_ok, data[31:0]).
REQ-006 SHALL have port: flush  input  1  invalidates the line (fence.i / satp write).
REQ-007 SHALL have port: creq  output  cbus_req_t  line-fill request, driven to one CBusArbiter ireqs slot.
REQ-008 SHALL have port: cresp  input  cbus_resp_t  response from that CBusArbiter slot.

Function
REQ-009 SHALL hold one line: data array of LINE_WORDS x 64 bits, tag = addr[63:log2(LINE_WORDS*8)], and a valid bit.
REQ-010 SHALL implement the states IDLE and FILL.
- IDLE -> FILL: ireq.valid and miss.
- FILL -> IDLE: cresp.ready and cresp.last.
REQ-011 SHALL treat a request as a hit when the state is IDLE, valid=1 and the tag matches.
- On a hit, addr_ok=data_ok=1 in the same cycle (combinational, zero latency).
- data = selected word[addr[2] ? 63:32 : 31:0], where the word index is addr[log2(LINE_WORDS*8)-1:3].
REQ-012 SHALL drive iresp all zero in every cycle that is not a hit.
REQ-013 SHALL, in FILL, drive creq with:
- valid=1, is_write=0, size=MSIZE8, strobe=0, data=0.
- addr = line-aligned ireq.addr (low offset bits zero).
- len = LINE_WORDS-1 encoding (MLEN8 for default), burst=AXI_BURST_INCR.
REQ-014 SHALL drive creq all zero in IDLE.
REQ-015 SHALL keep a beat counter that is zeroed on entry to FILL and incremented on each cresp.ready.
- Each ready beat writes cresp.data into word[counter].
- The counter wraps modulo LINE_WORDS.
REQ-016 SHALL, when cresp.last arrives, write the tag and set valid=1 unless the line is poisoned; the held request then hits in the following IDLE cycle.
- Miss latency = fill beats + 1 cycle.
REQ-017 SHALL clear valid in the next cycle when flush is asserted in IDLE.
- A hit and a flush in the same cycle SHALL still return data for that cycle.
REQ-018 SHALL set a poison flag when flush is asserted during FILL.
- The burst runs to completion; creq is never dropped mid-burst.
- On last with poison=1, valid is left 0, poison is cleared, and the held request re-misses and refills.
REQ-019 SHALL ignore ireq.addr[1:0].
REQ-020 SHALL ignore ireq changes during FILL (the protocol forbids them).

Reset
REQ-021 SHALL, when reset=0 (asynchronously): state=IDLE, valid=0, poison=0, counter=0, creq=0, iresp=0.
REQ-022 SHALL NOT reset the data array.
REQ-023 SHALL NOT retain partial line data after reset mid-FILL; the fill is abandoned and valid=0.

Configuration
REQ-024 SHALL, when IFETCH_LINE_BUFFER_STATS_EN is defined, add the following outputs:
- hit_cnt  output  32: increments once per hit cycle.
- miss_cnt  output  32: increments once per IDLE->FILL transition.
- Both wrap at 2^32 and are reset to 0.
REQ-025 SHALL, when IFETCH_LINE_BUFFER_STATS_EN is undefined, have no such ports, with all other behaviour identical.

Verification
REQ-026 SHALL verify cold miss: after reset, ireq addr=0x8000_0004.
- creq addr=0x8000_0000, len=MLEN8.
- 8 beats data=i*0x0101...01.
- One cycle after last: data_ok=1, data=0x01010101.
REQ-027 SHALL verify back-to-back hits: addr 0x8000_0008 then 0x8000_003C.
- data_ok in the same cycle as each request.
- Data = low half of word1, then high half of word7.
- No creq.valid.
REQ-028 SHALL verify conflict miss: addr 0x8000_0040 after the REQ-026 fill.
- A new burst with addr=0x8000_0040.
- Old line replaced; 0x8000_0004 re-misses afterwards.
REQ-029 SHALL verify flush during FILL at beat 3.
- All 8 beats are accepted.
- data_ok stays 0 and a second identical burst is issued.
- data_ok follows the second last beat.
REQ-030 SHALL verify reset mid-FILL: reset=0 at beat 5, then released.
- creq=0 and iresp=0 immediately.
- Same request re-misses from beat 0.
REQ-031 SHALL verify statistics with STATS_EN: sequence miss, hit, hit, flush, miss gives hit_cnt=2 and miss_cnt=2.

Source files
------------

// File: rtl/ifetch_line_buffer.sv
// Single-line instruction fetch buffer in front of one CBusArbiter slot.
// Latency: hits answer combinationally in the request cycle; a miss answers one cycle after the last fill beat.
// Backpressure: the held request is not acknowledged until the line is valid; fill beats advance only on cresp.ready.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset
//   ireq   - fetch request (valid, addr), held stable until data_ok
//   iresp  - fetch response (addr_ok, data_ok, 32-bit data); all zero unless hitting
//   flush  - invalidates the line (fence.i / satp write)
//   creq   - line-fill burst request towards the bus arbiter
//   cresp  - fill beats (ready, last, 64-bit data) from the arbiter
// Optional: define IFETCH_LINE_BUFFER_STATS_EN to add hit_cnt / miss_cnt outputs.

package ifetch_line_buffer_pkg;
  typedef logic [2:0] msize_t;
  typedef logic [3:0] mlen_t;
  typedef logic [1:0] axi_burst_t;

  localparam msize_t     MSIZE8         = 3'd3;
  localparam mlen_t      MLEN8          = 4'd7;
  localparam axi_burst_t AXI_BURST_INCR = 2'b01;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
    mlen_t       len;
    axi_burst_t  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module ifetch_line_buffer
  import ifetch_line_buffer_pkg::*;
#(
  parameter int LINE_WORDS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  logic       flush,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
`ifdef IFETCH_LINE_BUFFER_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS * 8);
  localparam int IDX_W = OFF_W - 3;
  localparam int TAG_W = 64 - OFF_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state_q, state_d;
  logic               line_vld_q;
  logic               poison_q;
  logic [IDX_W-1:0]   beat_q;
  logic [TAG_W-1:0]   tag_q;
  logic [TAG_W-1:0]   fill_tag_q;
  logic [63:0]        line_q [LINE_WORDS];

  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   req_idx;
  logic [63:0]        hit_word;
  logic               hit;
  logic               miss_start;
  logic [1:0]         unused_addr_lo;

  assign req_tag        = ireq.addr[63:OFF_W];
  assign req_idx        = ireq.addr[OFF_W-1:3];
  assign hit_word       = line_q[req_idx];
  // Byte offset within a 32-bit instruction word carries no information here.
  assign unused_addr_lo = ireq.addr[1:0];

  assign hit        = (state_q == IDLE) && ireq.valid && line_vld_q && (tag_q == req_tag);
  assign miss_start = (state_q == IDLE) && ireq.valid && !hit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss_start) state_d = FILL;
      FILL:    if (cresp.ready && cresp.last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    iresp = '0;
    creq  = '0;
    if (hit) begin
      iresp.addr_ok = 1'b1;
      iresp.data_ok = 1'b1;
      iresp.data    = ireq.addr[2] ? hit_word[63:32] : hit_word[31:0];
    end
    if (state_q == FILL) begin
      creq.valid = 1'b1;
      creq.addr  = {fill_tag_q, {OFF_W{1'b0}}};
      creq.size  = MSIZE8;
      creq.len   = mlen_t'(LINE_WORDS - 1);
      creq.burst = AXI_BURST_INCR;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      line_vld_q <= 1'b0;
      poison_q   <= 1'b0;
      beat_q     <= '0;
      tag_q      <= '0;
      fill_tag_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss_start) begin
        // The old line is overwritten beat by beat, so it stops being valid now.
        fill_tag_q <= req_tag;
        beat_q     <= '0;
        line_vld_q <= 1'b0;
        poison_q   <= 1'b0;
      end else if ((state_q == IDLE) && flush) begin
        line_vld_q <= 1'b0;
      end
      if (state_q == FILL) begin
        if (flush) poison_q <= 1'b1;
        if (cresp.ready) begin
          beat_q <= beat_q + 1'b1;
          if (cresp.last) begin
            beat_q   <= '0;
            poison_q <= 1'b0;
            // A flush on the last beat itself must also keep the line invalid.
            if (!(poison_q || flush)) begin
              line_vld_q <= 1'b1;
              tag_q      <= fill_tag_q;
            end
          end
        end
      end
    end
  end

  // Line storage carries no reset; line_vld_q guards every read.
  always_ff @(posedge clk) begin
    if ((state_q == FILL) && cresp.ready) line_q[beat_q] <= cresp.data;
  end

`ifdef IFETCH_LINE_BUFFER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit)        hit_cnt  <= hit_cnt + 32'd1;
      if (miss_start) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ifetch_line_buffer.sv
// Bench for ifetch_line_buffer: directed fetch sequences with a response/burst scoreboard.
// Latency: expected responses carry the cycle in which data_ok must appear.
// Backpressure: the bench acts as the arbiter slot, returning one fill beat per cycle.

module tb_ifetch_line_buffer;
  import ifetch_line_buffer_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  logic       flush;
  cbus_req_t  creq;
  cbus_resp_t cresp;
`ifdef IFETCH_LINE_BUFFER_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  ifetch_line_buffer #(.LINE_WORDS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .ireq  (ireq),
    .iresp (iresp),
    .flush (flush),
    .creq  (creq),
    .cresp (cresp)
`ifdef IFETCH_LINE_BUFFER_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_resp_t;

  exp_resp_t   resp_q[$];
  logic [63:0] burst_q[$];
  exp_resp_t   e;
  logic [63:0] ea;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_hit_exp = 0;
  int          n_miss_exp = 0;
  bit          in_burst = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every data_ok and every burst start is matched against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      in_burst = 1'b0;
    end else begin
      if (iresp.data_ok) begin
        if (resp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_data_ok: got data %h with none expected (cycle %0d)", iresp.data, cyc);
        end else begin
          e = resp_q.pop_front();
          check("resp_cycle", 64'(cyc), 64'(e.cyc));
          check("resp_data", 64'(iresp.data), 64'(e.data));
          check("resp_addr_ok", 64'(iresp.addr_ok), 64'd1);
        end
      end
      if (in_burst) check("creq_held", 64'(creq.valid), 64'd1);
      if (creq.valid && !in_burst) begin
        in_burst = 1'b1;
        if (burst_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_burst: got addr %h with none expected (cycle %0d)", creq.addr, cyc);
        end else begin
          ea = burst_q.pop_front();
          check("burst_addr", creq.addr, ea);
          check("burst_len", 64'(creq.len), 64'(MLEN8));
          check("burst_ctl", {creq.is_write, creq.size, creq.burst, creq.strobe},
                {1'b0, MSIZE8, AXI_BURST_INCR, 8'h00});
          check("burst_wdata", creq.data, 64'd0);
        end
      end
      if (cresp.ready && cresp.last) in_burst = 1'b0;
    end
  end

  function automatic logic [63:0] pat(input int i, input logic [63:0] salt);
    return (64'(i + 1) * 64'h0101_0101_0101_0101) ^ salt;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [63:0] addr);
    ireq.valid = 1'b1;
    ireq.addr  = addr;
  endtask

  task automatic expect_burst(input logic [63:0] addr);
    burst_q.push_back(addr);
    n_miss_exp++;
  endtask

  task automatic wait_creq(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (creq.valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL creq_timeout: got no creq.valid within 20 cycles, required one");
    end
  endtask

  // Acts as the arbiter slot: one beat per cycle, optional flush or reset at a given beat.
  task automatic serve(input logic [63:0] salt, input int flush_beat, input int reset_beat,
                       input bit push, input logic [31:0] exp_data);
    bit ok;
    exp_resp_t r;
    wait_creq(ok);
    if (!ok) return;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == reset_beat) begin
        reset = 1'b0;
        cresp = '0;
        flush = 1'b0;
        n_hit_exp = 0;
        n_miss_exp = 0;
        #1;
        check("reset_creq_zero", 64'(|creq), 64'd0);
        check("reset_iresp_zero", 64'(|iresp), 64'd0);
        tick();
        reset = 1'b1;
        return;
      end
      cresp.ready = 1'b1;
      cresp.last  = (i == 7);
      cresp.data  = pat(i, salt);
      flush       = (i == flush_beat);
      if (i == 7 && push) begin
        r.cyc  = cyc + 1;
        r.data = exp_data;
        resp_q.push_back(r);
        n_hit_exp++;
      end
    end
    tick();
    cresp = '0;
    flush = 1'b0;
  endtask

  task automatic hit(input logic [63:0] addr, input logic [31:0] exp_data);
    exp_resp_t r;
    set_req(addr);
    r.cyc  = cyc;
    r.data = exp_data;
    resp_q.push_back(r);
    n_hit_exp++;
    @(negedge clk);
    check("hit_no_creq", 64'(creq.valid), 64'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_resp_t r;
    ireq  = '0;
    flush = 1'b0;
    cresp = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_creq_zero", 64'(|creq), 64'd0);
    check("rst_iresp_zero", 64'(|iresp), 64'd0);
    reset = 1'b1;
    tick();

    // Cold miss: word0 high half one cycle after the last beat.
    expect_burst(64'h8000_0000);
    set_req(64'h8000_0004);
    serve(64'd0, -1, -1, 1'b1, 32'h0101_0101);
    tick();
    ireq.valid = 1'b0;
    tick();

    // Back-to-back hits, including ignored addr[1:0].
    hit(64'h8000_0008, 32'h0202_0202);
    hit(64'h8000_003C, 32'h0808_0808);
    hit(64'h8000_000B, 32'h0202_0202);
    ireq.valid = 1'b0;
    tick();

    // Conflict miss to the next line, then the old line re-misses.
    expect_burst(64'h8000_0040);
    set_req(64'h8000_0040);
    serve(64'hA5A5_A5A5_A5A5_A5A5, -1, -1, 1'b1, 32'hA4A4_A4A4);
    tick();
    ireq.valid = 1'b0;
    tick();
    expect_burst(64'h8000_0000);
    set_req(64'h8000_0004);
    serve(64'd0, -1, -1, 1'b1, 32'h0101_0101);
    tick();
    ireq.valid = 1'b0;
    tick();

    // Hit and flush in the same cycle: data returned, next cycle re-misses.
    set_req(64'h8000_0010);
    flush = 1'b1;
    r.cyc  = cyc;
    r.data = 32'h0303_0303;
    resp_q.push_back(r);
    n_hit_exp++;
    expect_burst(64'h8000_0000);
    tick();
    flush = 1'b0;
    serve(64'd0, -1, -1, 1'b1, 32'h0303_0303);
    tick();
    ireq.valid = 1'b0;
    tick();

    // Flush during fill at beat 3: full burst, no data_ok, identical second burst.
    expect_burst(64'h8000_0080);
    expect_burst(64'h8000_0080);
    set_req(64'h8000_0084);
    serve(64'hFFFF_FFFF_FFFF_FFFF, 3, -1, 1'b0, 32'h0);
    serve(64'h1111_1111_1111_1111, -1, -1, 1'b1, 32'h1010_1010);
    tick();
    ireq.valid = 1'b0;
    tick();

    // Reset at beat 5, then the same request refills from beat 0.
    expect_burst(64'h8000_00C0);
    set_req(64'h8000_00C0);
    serve(64'h5A5A_5A5A_5A5A_5A5A, -1, 5, 1'b0, 32'h0);
    expect_burst(64'h8000_00C0);
    serve(64'h2222_2222_2222_2222, -1, -1, 1'b1, 32'h2323_2323);
    tick();
    ireq.valid = 1'b0;
    tick();
    tick();

    check("resp_queue_drained", 64'(resp_q.size()), 64'd0);
    check("burst_queue_drained", 64'(burst_q.size()), 64'd0);
`ifdef IFETCH_LINE_BUFFER_STATS_EN
    check("hit_cnt", 64'(hit_cnt), 64'(n_hit_exp));
    check("miss_cnt", 64'(miss_cnt), 64'(n_miss_exp));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
